// File: rtl/result_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | result_writer: buffers thresholded Sobel gradients in a small FIFO and     |
// | writes them to output memory at address {Row, Column} with a req/ack port. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module result_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_dop,
  input  logic [7:0]        i_gradient,
  input  logic [7:0]        i_row,
  input  logic [7:0]        i_column,
  input  logic              i_is_end,
  input  logic              i_mem_ack,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow,
  output logic [16:0]       o_pix_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 8;
  localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(FIFO_DEPTH);
  localparam logic [16:0]      C_PIX_MAX = 17'h10000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_clear;
  logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr;
  logic [PTR_W-1:0]   r_rd;
  logic [CNT_W-1:0]   r_count;
  logic [16:0]        r_pix;
  logic               r_ovf;
  logic               w_we;
  logic               w_pop;
  logic               w_push_req;
  logic               w_full;
  logic               w_push;
  logic               w_drop;
  logic [ENT_W-1:0]   w_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next  = S_RUN;
          w_clear = 1'b1;
        end
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (i_is_end) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        // No push happens in DRAIN and a pop needs a non-empty FIFO,
        // so an empty FIFO alone means nothing is in flight.
        if (r_count == '0) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        if (i_start) begin
          w_next  = S_RUN;
          w_clear = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_we       = o_busy && (r_count != '0);
  assign w_pop      = w_we && i_mem_ack;
  assign w_push_req = (r_state == S_RUN) && i_dop;
  assign w_full     = (r_count == C_FULL);
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_entry    = {ADDR_W'({i_row, i_column}), i_gradient};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr] <= w_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_pix   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_pix   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
        if (r_pix != C_PIX_MAX) r_pix <= r_pix + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign o_mem_we    = w_we;
  assign o_mem_addr  = r_mem[r_rd][ENT_W-1:8];
  assign o_mem_data  = r_mem[r_rd][7:0];
  assign o_overflow  = r_ovf;
  assign o_pix_count = r_pix;

endmodule
`default_nettype wire

// File: tb/tb_result_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_result_writer: directed self-checking bench for result_writer.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_result_writer;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_dop;
  logic [7:0]  i_gradient;
  logic [7:0]  i_row;
  logic [7:0]  i_column;
  logic        i_is_end;
  logic        i_mem_ack;
  logic        o_mem_we;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_data;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow;
  logic [16:0] o_pix_count;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] exp_addr [4];
  logic [7:0]  exp_data [4];

  result_writer #(.FIFO_DEPTH(4), .ADDR_W(16)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_dop       (i_dop),
    .i_gradient  (i_gradient),
    .i_row       (i_row),
    .i_column    (i_column),
    .i_is_end    (i_is_end),
    .i_mem_ack   (i_mem_ack),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_data  (o_mem_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_overflow  (o_overflow),
    .o_pix_count (o_pix_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] r, input logic [7:0] c, input logic [7:0] g);
    i_dop = 1'b1; i_row = r; i_column = c; i_gradient = g;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 8 && !o_done; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_dop = 1'b0; i_gradient = '0;
    i_row = '0; i_column = '0; i_is_end = 1'b0; i_mem_ack = 1'b0;
    #12;
    chk("rst_we",   32'(o_mem_we), 32'd0);
    chk("rst_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_data", 32'(o_mem_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_ovf",  32'(o_overflow), 32'd0);
    chk("rst_pix",  32'(o_pix_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Frame A: single write
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("a_busy", 32'(o_busy), 32'd1);
    sample(8'd2, 8'd3, 8'hFF); i_mem_ack = 1'b1; tick(); i_dop = 1'b0;
    chk("a_we",   32'(o_mem_we), 32'd1);
    chk("a_addr", 32'(o_mem_addr), 32'h0203);
    chk("a_data", 32'(o_mem_data), 32'hFF);
    chk("a_pix0", 32'(o_pix_count), 32'd0);
    tick();
    chk("a_pix1", 32'(o_pix_count), 32'd1);
    chk("a_we0",  32'(o_mem_we), 32'd0);
    i_is_end = 1'b1; tick(); i_is_end = 1'b0;
    wait_done();
    chk("a_done", 32'(o_done), 32'd1);
    chk("a_busy0", 32'(o_busy), 32'd0);

    // Frame B: back-pressure, full FIFO, push+pop at full, overflow
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("b_pix_clr", 32'(o_pix_count), 32'd0);
    i_mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample(8'(8'h10 + i), 8'(8'h20 + i), 8'(8'hA0 + i));
      tick();
    end
    i_dop = 1'b0;
    tick();
    chk("b_hold_addr", 32'(o_mem_addr), 32'h1020);
    chk("b_hold_data", 32'(o_mem_data), 32'hA0);
    chk("b_full_ovf",  32'(o_overflow), 32'd0);
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("b_start_ign", 32'(o_mem_addr), 32'h1020);
    sample(8'h40, 8'h41, 8'hC4); i_mem_ack = 1'b1; tick();
    chk("b_pp_ovf",  32'(o_overflow), 32'd0);
    chk("b_pp_pix",  32'(o_pix_count), 32'd1);
    chk("b_pp_addr", 32'(o_mem_addr), 32'h1121);
    sample(8'h55, 8'h66, 8'h77); i_mem_ack = 1'b0; tick(); i_dop = 1'b0;
    chk("b_drop_ovf",  32'(o_overflow), 32'd1);
    chk("b_drop_addr", 32'(o_mem_addr), 32'h1121);
    exp_addr[0] = 16'h1121; exp_data[0] = 8'hA1;
    exp_addr[1] = 16'h1222; exp_data[1] = 8'hA2;
    exp_addr[2] = 16'h1323; exp_data[2] = 8'hA3;
    exp_addr[3] = 16'h4041; exp_data[3] = 8'hC4;
    i_mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_wr%0d_we", i),   32'(o_mem_we), 32'd1);
      chk($sformatf("b_wr%0d_addr", i), 32'(o_mem_addr), 32'(exp_addr[i]));
      chk($sformatf("b_wr%0d_data", i), 32'(o_mem_data), 32'(exp_data[i]));
      tick();
    end
    chk("b_empty_we", 32'(o_mem_we), 32'd0);
    chk("b_pix5",     32'(o_pix_count), 32'd5);
    chk("b_ovf_stk",  32'(o_overflow), 32'd1);
    sample(8'h50, 8'h51, 8'h5A); i_is_end = 1'b1; tick(); i_is_end = 1'b0;
    chk("b_last_addr", 32'(o_mem_addr), 32'h5051);
    chk("b_drain_busy", 32'(o_busy), 32'd1);
    sample(8'h99, 8'h99, 8'h99); tick(); i_dop = 1'b0;
    wait_done();
    chk("b_done",    32'(o_done), 32'd1);
    chk("b_done_we", 32'(o_mem_we), 32'd0);
    chk("b_pix6",    32'(o_pix_count), 32'd6);
    tick(); tick();
    chk("b_done_hold", 32'(o_done), 32'd1);

    // Frame C: full image plus three extra samples, count saturates
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("c_ovf_clr", 32'(o_overflow), 32'd0);
    for (int k = 0; k < 65539; k++) begin
      sample(8'(k >> 8), 8'(k), 8'(k));
      i_is_end = (k == 65538);
      tick();
      if (k == 999)   chk("c_pix999", 32'(o_pix_count), 32'd999);
      if (k == 65535) chk("c_pix65535", 32'(o_pix_count), 32'd65535);
    end
    i_dop = 1'b0; i_is_end = 1'b0;
    wait_done();
    chk("c_done", 32'(o_done), 32'd1);
    chk("c_pix_sat", 32'(o_pix_count), 32'h10000);
    chk("c_ovf", 32'(o_overflow), 32'd0);

    // Frame D: reset with pending entries
    i_start = 1'b1; tick(); i_start = 1'b0;
    i_mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample(8'(8'h70 + i), 8'h01, 8'h11);
      tick();
    end
    i_dop = 1'b0; i_mem_ack = 1'b1; tick(); i_mem_ack = 1'b0;
    chk("d_pend_pix", 32'(o_pix_count), 32'd1);
    rst_n = 1'b0; #2;
    chk("d_rst_we",   32'(o_mem_we), 32'd0);
    chk("d_rst_pix",  32'(o_pix_count), 32'd0);
    chk("d_rst_addr", 32'(o_mem_addr), 32'd0);
    chk("d_rst_busy", 32'(o_busy), 32'd0);
    #5; rst_n = 1'b1;
    i_mem_ack = 1'b1; tick(); tick();
    chk("d_idle_we", 32'(o_mem_we), 32'd0);
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick(); tick(); tick();
    chk("d_no_stale_we",  32'(o_mem_we), 32'd0);
    chk("d_no_stale_pix", 32'(o_pix_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
